port_out_demux: RTL

//  Output side of the processor I/O port pair: decodes processor OUT writes
//  (port_id/out_port/write_strobe) into registered output ports.

---
 rtl/port_out_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/port_out_demux.sv | 103 ++++++++++
 3 files changed

// File: rtl/port_out_pkg.sv
// Shared port map and PBout select encodings for the processor I/O port pair.
package port_out_pkg;

    // Default port_id assignments, shared with the input-side mux
    localparam logic [7:0] ADDR_SEL   = 8'h00;
    localparam logic [7:0] ADDR_LED   = 8'h01;
    localparam logic [7:0] ADDR_DISP0 = 8'h02;
    localparam logic [7:0] ADDR_DISP1 = 8'h03;
    localparam logic [7:0] ADDR_TX    = 8'h04;
    localparam logic [7:0] ADDR_CLR   = 8'h05;

    // PBout values steering the input-port multiplexer
    typedef enum logic [1:0] {
        SEL_DATA  = 2'd0,
        SEL_BYTE0 = 2'd1,
        SEL_BYTE1 = 2'd2,
        SEL_BCD   = 2'd3
    } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head data is gated to zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only meaningful under the count, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/port_out_demux.sv
// Decodes processor OUT writes into registered output ports and a TX FIFO.
module port_out_demux #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ADDR_SEL   = port_out_pkg::ADDR_SEL,
    parameter logic [7:0] ADDR_LED   = port_out_pkg::ADDR_LED,
    parameter logic [7:0] ADDR_DISP0 = port_out_pkg::ADDR_DISP0,
    parameter logic [7:0] ADDR_DISP1 = port_out_pkg::ADDR_DISP1,
    parameter logic [7:0] ADDR_TX    = port_out_pkg::ADDR_TX,
    parameter logic [7:0] ADDR_CLR   = port_out_pkg::ADDR_CLR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [1:0] PBout,
    output logic [7:0] LED,
    output logic [7:0] DISP0,
    output logic [7:0] DISP1,
    output logic       disp_upd,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_full,
    output logic       overflow
);

    import port_out_pkg::*;

    logic                        wr_sel;
    logic                        wr_led;
    logic                        wr_disp0;
    logic                        wr_disp1;
    logic                        wr_tx;
    logic                        wr_clr;
    logic                        tx_pop;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    sel_e                        sel_next;

    assign wr_sel   = write_strobe && (port_id == ADDR_SEL);
    assign wr_led   = write_strobe && (port_id == ADDR_LED);
    assign wr_disp0 = write_strobe && (port_id == ADDR_DISP0);
    assign wr_disp1 = write_strobe && (port_id == ADDR_DISP1);
    assign wr_tx    = write_strobe && (port_id == ADDR_TX);
    assign wr_clr   = write_strobe && (port_id == ADDR_CLR);

    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign sel_next = sel_e'(out_port[1:0]);

    // Output port registers loaded by matching processor writes
    always_ff @(posedge clk) begin
        if (rst) begin
            PBout    <= SEL_DATA;
            LED      <= '0;
            DISP0    <= '0;
            DISP1    <= '0;
            disp_upd <= 1'b0;
        end else begin
            if (wr_sel) begin
                PBout <= sel_next;
            end
            if (wr_led) begin
                LED <= out_port;
            end
            if (wr_disp0) begin
                DISP0 <= out_port;
            end
            if (wr_disp1) begin
                DISP1 <= out_port;
            end
            disp_upd <= wr_disp0 || wr_disp1;
        end
    end

    // Sticky overflow: a TX push that finds the FIFO full with no pop to make room
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_clr) begin
            overflow <= 1'b0;
        end else if (wr_tx && tx_full && !tx_pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (out_port),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
